// File: rtl/rvv_backend_mac_issue_sched.sv
// Issue scheduler between the MUL reservation-station FIFO and two MAC lanes.
// Issue is combinational from the FIFO flags; credits, pointer and flush drain are registered.
module rvv_backend_mac_issue_sched #(
  parameter  int MAC_LAT   = 3,
  parameter  int BUF_DEPTH = 4,
  localparam int CRD_W     = $clog2(BUF_DEPTH + 1)
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       trap_flush_rvv,
  input  logic       rs2ex_fifo_empty,
  input  logic       rs2ex_fifo_1left_to_empty,
  output logic [1:0] ex2rs_fifo_pop,
  output logic [1:0] lane_issue_valid,
  output logic [1:0] lane_issue_sel,
  input  logic [1:0] lane_deq,
  output logic       lane_flush,
  output logic       sched_ptr,
  output logic       sched_busy
);

  localparam int DW = $clog2(MAC_LAT + 1);
  localparam logic [CRD_W-1:0] CRD_FULL   = CRD_W'(BUF_DEPTH);
  localparam logic [DW-1:0]    DRAIN_INIT = DW'(MAC_LAT);

  typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_e;

  state_e           state_q, state_d;
  logic             sched_q, sched_d;
  logic [CRD_W-1:0] crd_q [2];
  logic [CRD_W-1:0] crd_d [2];
  logic [DW-1:0]    drain_q, drain_d;

  logic [1:0]       avail;
  logic             can_iss, iss0, iss1;
  logic [1:0]       lane_iss;
  logic [CRD_W:0]   crd_sum [2];

  // Head1 only issues behind head0, so the lane pair is always filled oldest-first.
  always_comb begin
    avail    = rs2ex_fifo_empty ? 2'd0 : (rs2ex_fifo_1left_to_empty ? 2'd1 : 2'd2);
    can_iss  = (state_q != FLUSH) && !trap_flush_rvv;
    iss0     = can_iss && (avail != 2'd0) && (crd_q[sched_q] != '0);
    iss1     = iss0 && (avail == 2'd2) && (crd_q[~sched_q] != '0);
    lane_iss = sched_q ? {iss0, iss1} : {iss1, iss0};
    for (int l = 0; l < 2; l++) begin
      crd_sum[l] = {1'b0, crd_q[l]} + {{CRD_W{1'b0}}, lane_deq[l]}
                 - {{CRD_W{1'b0}}, lane_iss[l]};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      sched_q  <= 1'b0;
      crd_q[0] <= CRD_FULL;
      crd_q[1] <= CRD_FULL;
      drain_q  <= '0;
    end else begin
      state_q  <= state_d;
      sched_q  <= sched_d;
      crd_q    <= crd_d;
      drain_q  <= drain_d;
    end
  end

  always_comb begin
    state_d = state_q;
    sched_d = sched_q;
    crd_d   = crd_q;
    drain_d = drain_q;
    case (state_q)
      IDLE, RUN: begin
        if (trap_flush_rvv) begin
          state_d = FLUSH;
          drain_d = DRAIN_INIT;
        end else begin
          for (int l = 0; l < 2; l++) begin
            crd_d[l] = (crd_sum[l] > {1'b0, CRD_FULL}) ? CRD_FULL : crd_sum[l][CRD_W-1:0];
          end
          sched_d = sched_q ^ (iss0 & ~iss1);
          state_d = (crd_d[0] == CRD_FULL && crd_d[1] == CRD_FULL) ? IDLE : RUN;
        end
      end
      FLUSH: begin
        // Credits held by killed uops are recovered wholesale on exit.
        if (trap_flush_rvv) begin
          drain_d = DRAIN_INIT;
        end else if (drain_q == DW'(1)) begin
          state_d  = IDLE;
          drain_d  = '0;
          sched_d  = 1'b0;
          crd_d[0] = CRD_FULL;
          crd_d[1] = CRD_FULL;
        end else begin
          drain_d = drain_q - DW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    ex2rs_fifo_pop   = {iss1, iss0};
    lane_issue_valid = lane_iss;
    lane_issue_sel   = sched_q ? {1'b0, iss1} : {iss1, 1'b0};
    lane_flush       = (state_q == FLUSH);
    sched_ptr        = sched_q;
    sched_busy       = (state_q != IDLE);
  end

  a_deq0_not_full: assert property (@(posedge clk) disable iff (!rst_n)
    (state_q != FLUSH) |-> !(lane_deq[0] && crd_q[0] == CRD_FULL));
  a_deq1_not_full: assert property (@(posedge clk) disable iff (!rst_n)
    (state_q != FLUSH) |-> !(lane_deq[1] && crd_q[1] == CRD_FULL));

endmodule
